// File: rtl/act_sched_pkg.sv
// Shared types and constants for the activation-unit scheduler.
// Tags are carried at a fixed 4-bit width so one entry type serves every N up to 16.
package act_sched_pkg;
  localparam int Z_W_DEF   = 8;
  localparam int PERF_W    = 16;
  localparam int TAG_MAX_W = 4;

  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;
endpackage

// File: rtl/act_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer,
// wrapping; the pointer advances past the winner only when a grant is issued.
module act_rr_arbiter
  import act_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [TAG_MAX_W-1:0] grant_idx,
  output logic                 hs
);
  localparam int TAG_W = tag_w(N);

  logic [TAG_W-1:0] ptr;
  logic             found;

  // Two passes: indices at/after the pointer first, then the wrapped remainder.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (i >= int'(ptr))) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = TAG_MAX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i]) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = TAG_MAX_W'(i);
      end
    end
  end

  // A grant only ever goes to an asserted request, so any grant is a handshake.
  assign hs = found;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (grant_idx == TAG_MAX_W'(N - 1)) ? '0 : TAG_W'(grant_idx + TAG_MAX_W'(1));
    end
  end
endmodule

// File: rtl/act_unit_scheduler.sv
// Time-shares one activation unit among N requesters: issue register, latency-matched
// tag pipe and response register. ACT_SCHED_PERF_EN adds a saturating grant counter.
module act_unit_scheduler
  import act_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int ACT_LAT = 0,
  parameter int Z_W     = Z_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*Z_W-1:0] req_z,
  output logic [Z_W-1:0]   act_z_value,
  input  logic [Z_W-1:0]   act_a,
  output logic [N-1:0]     rsp_valid,
  output logic [Z_W-1:0]   rsp_a,
  output logic             busy
`ifdef ACT_SCHED_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [PERF_W-1:0] perf_grants
`endif
);
  logic [TAG_MAX_W-1:0] grant_idx;
  logic                 hs;
  logic [Z_W-1:0]       z_sel;
  logic [N-1:0]         aln_onehot;
  logic                 pipe_busy;
  tag_entry_t           iss_e;
  tag_entry_t           aln_e;

  act_rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx),
    .hs        (hs)
  );

  always_comb begin
    z_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) z_sel = req_z[i*Z_W +: Z_W];
    end
  end

  // act_z_value keeps its last value when nothing is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_e       <= '0;
      act_z_value <= '0;
    end else begin
      iss_e <= {hs, grant_idx};
      if (hs) act_z_value <= z_sel;
    end
  end

  // The entry presented alongside act_a is the issue entry delayed by ACT_LAT cycles.
  generate
    if (ACT_LAT == 0) begin : g_no_pipe
      assign aln_e     = iss_e;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      tag_entry_t pipe [ACT_LAT];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < ACT_LAT; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= iss_e;
          for (int k = 1; k < ACT_LAT; k++) pipe[k] <= pipe[k-1];
        end
      end

      always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < ACT_LAT; k++) pipe_busy = pipe_busy | pipe[k].valid;
      end

      assign aln_e = pipe[ACT_LAT-1];
    end
  endgenerate

  always_comb begin
    aln_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (aln_e.tag == TAG_MAX_W'(i)) aln_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_a     <= '0;
    end else begin
      rsp_valid <= aln_e.valid ? aln_onehot : '0;
      if (aln_e.valid) rsp_a <= act_a;
    end
  end

  assign busy = iss_e.valid | pipe_busy;

`ifdef ACT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grants <= '0;
    end else if (perf_clr) begin
      perf_grants <= '0;
    end else if (hs && (perf_grants != '1)) begin
      perf_grants <= perf_grants + PERF_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_act_unit_scheduler.sv
// Bench for act_unit_scheduler: two instances (ACT_LAT 0 and 3) share one stimulus stream
// and are checked every cycle against a handshake-log model plus literal expectations.
module tb_act_unit_scheduler;
  localparam int N    = 4;
  localparam int ZW   = 8;
  localparam int LAT1 = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [ZW-1:0] z [N];
  logic [N*ZW-1:0] req_z;
  logic [N-1:0]  ready0, ready1, rv0, rv1;
  logic [ZW-1:0] az0, az1, aa0, aa1, ra0, ra1;
  logic          busy0, busy1;
  logic [ZW-1:0] s1 = '0, s2 = '0, s3 = '0;
`ifdef ACT_SCHED_PERF_EN
  logic          perf_clr = 1'b0;
  logic [15:0]   pg0, pg1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int            t;
    int            tag;
    logic [ZW-1:0] z;
  } exp_t;
  exp_t exp_q[$];

  int            ptr_m  = 0;
  logic [ZW-1:0] last_z = '0;
  logic [ZW-1:0] exp_a0 = '0;
  logic [ZW-1:0] exp_a1 = '0;

  // ---------------- clock / reset / DUTs ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_z = '0;
    for (int i = 0; i < N; i++) req_z[i*ZW +: ZW] = z[i];
  end

  // Identity activation stubs: combinational, and delayed by three cycles.
  assign aa0 = az0;
  always @(posedge clk) begin
    s1 <= az1;
    s2 <= s1;
    s3 <= s2;
  end
  assign aa1 = s3;

  act_unit_scheduler #(.N(N), .ACT_LAT(0), .Z_W(ZW)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(ready0),
    .req_z(req_z), .act_z_value(az0), .act_a(aa0), .rsp_valid(rv0), .rsp_a(ra0),
    .busy(busy0)
`ifdef ACT_SCHED_PERF_EN
    , .perf_clr(perf_clr), .perf_grants(pg0)
`endif
  );

  act_unit_scheduler #(.N(N), .ACT_LAT(LAT1), .Z_W(ZW)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(ready1),
    .req_z(req_z), .act_z_value(az1), .act_a(aa1), .rsp_valid(rv1), .rsp_a(ra1),
    .busy(busy1)
`ifdef ACT_SCHED_PERF_EN
    , .perf_clr(perf_clr), .perf_grants(pg1)
`endif
  );

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Response due in this cycle for a given latency, and whether work is in flight.
  task automatic model_rsp(input int lat, output logic [N-1:0] erv, output logic eb,
                           inout logic [ZW-1:0] ea);
    erv = '0;
    eb  = 1'b0;
    foreach (exp_q[j]) begin
      if (exp_q[j].t + 2 + lat == cyc) begin
        erv = N'(1) << exp_q[j].tag;
        ea  = exp_q[j].z;
      end
      if ((cyc >= exp_q[j].t + 1) && (cyc <= exp_q[j].t + 1 + lat)) eb = 1'b1;
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    int            g;
    logic [N-1:0]  er, erv0, erv1;
    logic          eb0, eb1;
    if (!rst) begin
      exp_q.delete();
      ptr_m  = 0;
      last_z = '0;
      exp_a0 = '0;
      exp_a1 = '0;
      chk("rst_rsp_valid0", rv0, 0);
      chk("rst_rsp_valid1", rv1, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_act_z0", az0, 0);
      chk("rst_rsp_a1", ra1, 0);
    end else begin
      g = -1;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          if ((g < 0) && req_valid[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        end
      end
      er = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready0", ready0, er);
      chk("req_ready1", ready1, er);
      chk("act_z0", az0, last_z);
      chk("act_z1", az1, last_z);
      model_rsp(0, erv0, eb0, exp_a0);
      model_rsp(LAT1, erv1, eb1, exp_a1);
      chk("rsp_valid0", rv0, erv0);
      chk("rsp_valid1", rv1, erv1);
      chk("rsp_a0", ra0, exp_a0);
      chk("rsp_a1", ra1, exp_a1);
      chk("busy0", busy0, eb0);
      chk("busy1", busy1, eb1);
      if (g >= 0) begin
        exp_q.push_back('{t: cyc, tag: g, z: z[g]});
        last_z = z[g];
        ptr_m  = (g + 1) % N;
      end
      while ((exp_q.size() > 0) && (exp_q[0].t + 2 + LAT1 < cyc)) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [4:0] pats [8];

  initial begin
    for (int i = 0; i < N; i++) z[i] = '0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);

    // Single request on requester 2.
    en = 1'b1;
    z[2] = 8'h35;
    req_valid = 4'b0100;
    #1 chk("t1_ready", ready0, 4'b0100);
    step();
    req_valid = '0;
    #1 chk("t1_act_z", az0, 8'h35);
    chk("t1_busy_c1", busy0, 1);
    step();
    chk("t1_rsp_valid", rv0, 4'b0100);
    chk("t1_rsp_a", ra0, 8'h35);
    chk("t1_busy_c2", busy0, 0);
    step(3);
    chk("t1_lat3_rsp_valid", rv1, 4'b0100);
    chk("t1_lat3_rsp_a", ra1, 8'h35);
    step(2);

    // All four valid straight out of reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < N; i++) z[i] = ZW'(8'h10 * i);
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 4) chk("t2_ready", ready0, 32'(1) << c);
      if (c >= 2) begin
        chk("t2_rsp_valid", rv0, 32'(1) << (c - 2));
        chk("t2_rsp_a", ra0, 32'(8'h10 * (c - 2)));
      end
      step();
    end
    req_valid = 4'b1111;
    #1 chk("t2_ptr_wrapped", ready0, 4'b0001);
    step();
    req_valid = '0;
    step(6);

    // Requesters 1 and 3 continuously valid; pointer is at 1.
    z[1] = 8'h11;
    z[3] = 8'h33;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8) ? 4'b1010 : 4'b0000;
      #1;
      if (c < 8) chk("t3_ready", ready0, (c % 2 == 0) ? 4'b0010 : 4'b1000);
      if (c >= 5) begin
        chk("t3_lat3_rsp_valid", rv1, ((c - 5) % 2 == 0) ? 4'b0010 : 4'b1000);
        chk("t3_lat3_rsp_a", ra1, ((c - 5) % 2 == 0) ? 8'h11 : 8'h33);
      end
      step();
    end
    step(2);

    // en drops after two grants; requester 0 re-requests and waits.
    z[0] = 8'h0A;
    z[2] = 8'h2A;
    req_valid = 4'b0101;
    step();
    z[0] = 8'h0B;
    step();
    en = 1'b0;
    req_valid = 4'b0001;
    #1 chk("t4_ready_off_c2", ready0, 0);
    step();
    chk("t4_busy0_fall", busy0, 0);
    chk("t4_rsp_a0", ra0, 8'h2A);
    step(3);
    chk("t4_busy1_fall", busy1, 0);
    chk("t4_lat3_rsp_valid", rv1, 4'b0100);
    chk("t4_ready_off_c6", ready0, 0);
    step(2);
    en = 1'b1;
    #1 chk("t4_ready_resume", ready0, 4'b0001);
    step();
    req_valid = '0;
    step(6);

    // Reset while two requests are in flight.
    req_valid = 4'b0101;
    step(2);
    req_valid = '0;
    rst = 1'b0;
    #1 chk("t5_rsp_clear", rv0, 0);
    chk("t5_busy1_clear", busy1, 0);
    chk("t5_act_z_clear", az1, 0);
    step(2);
    rst = 1'b1;
    step(6);
    z[3] = 8'h77;
    req_valid = 4'b1000;
    #1 chk("t5_fresh_ready", ready0, 4'b1000);
    step();
    req_valid = '0;
    step();
    chk("t5_fresh_rsp_valid", rv0, 4'b1000);
    chk("t5_fresh_rsp_a", ra0, 8'h77);
    step(3);
    chk("t5_fresh_lat3_rsp", rv1, 4'b1000);
    step(2);

    // Mixed directed patterns {en, req_valid}.
    pats[0] = 5'b1_0101; pats[1] = 5'b1_0101; pats[2] = 5'b0_1111; pats[3] = 5'b1_1111;
    pats[4] = 5'b1_0010; pats[5] = 5'b1_1000; pats[6] = 5'b1_1001; pats[7] = 5'b1_0000;
    for (int i = 0; i < N; i++) z[i] = ZW'(8'hA0 + i);
    foreach (pats[p]) begin
      en        = pats[p][4];
      req_valid = pats[p][3:0];
      step();
    end
    en = 1'b1;
    req_valid = '0;
    step(6);

`ifdef ACT_SCHED_PERF_EN
    req_valid = 4'b1111;
    step(70000);
    chk("perf_sat0", pg0, 16'hFFFF);
    chk("perf_sat1", pg1, 16'hFFFF);
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr0", pg0, 0);
    chk("perf_clr1", pg1, 0);
    req_valid = '0;
    step(6);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
